multi_blinker: RTL and testbench
================================

Name: multi_blinker

Overview:
- Parametrised, multi-channel successor to the single fixed-rate LED divider.
- N_CH independent channels, each with a programmable terminal count, an enable and a mode (square-wave toggle or one-cycle strobe).
- Sits between the board clock and LEDs / slow-rate consumers.
- Configured at run time through a single-cycle write port.

Parameters:
- N_CH, 4, number of channels (1..16).
- CNT_W, 32, counter and terminal-count width in bits.
- DEFAULT_TERM, 49999999, terminal count loaded at reset (1 s event period at 50 MHz).
- CH_W, derived as max(1, clog2(N_CH)), channel index width (localparam, not overridable).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- WR_EN  in  1  config write strobe, one cycle.
- WR_CH  in  CH_W  target channel index.
- WR_TERM  in  CNT_W  new terminal count.
- WR_MODE  in  1  0 = toggle, 1 = strobe.
- WR_ENA  in  1  channel enable.
- OUT  out  N_CH  per-channel output: square wave (toggle) or strobe.
- TICK  out  N_CH  per-channel one-cycle event pulse, independent of mode.

Behaviour:
- Reset (RST sampled high at a CLK edge):
  - every channel: cnt = 0, term = DEFAULT_TERM, mode = toggle, ena = 1;
  - OUT = 0, TICK = 0.
  - RST has priority over WR_EN and over events.
  - Reset mid-period discards the partial count.
- Per-channel counter, when ena = 1:
  - cnt increments by 1 each cycle;
  - when cnt == term: the event fires and cnt wraps to 0 on the same edge.
  - Event period = term + 1 cycles.
  - term = 0 gives an event every cycle.
  - term = 2^CNT_W - 1 is legal; no overflow is possible because the wrap happens at term.
- Event in cycle k (cnt == term during cycle k). Registered outputs are visible in cycle k+1:
  - TICK[ch] = 1 for exactly one cycle.
  - Toggle mode: OUT[ch] inverts.
  - Strobe mode: OUT[ch] = 1 for exactly one cycle, otherwise 0.
- Disabled channel (ena = 0):
  - cnt held at 0, TICK = 0;
  - toggle mode: OUT holds its last value; strobe mode: OUT = 0.
- Config write (WR_EN = 1, WR_CH < N_CH), on that edge:
  - term, mode and ena of WR_CH are loaded;
  - cnt is cleared to 0;
  - TICK of WR_CH = 0 in the next cycle.
  - OUT of WR_CH: holds if the new mode is toggle, cleared if the new mode is strobe.
  - The first event after the write occurs WR_TERM + 1 cycles later, counted from the write edge.
- Write colliding with an event on the same channel in the same cycle: the write wins. That event is suppressed (no TICK, no OUT change).
- Writes never affect other channels; their events proceed normally.
- WR_CH >= N_CH: write ignored, no state change.
- Multiple channels may fire in the same cycle; there is no arbitration.

Decomposition:
- Package multi_blinker_pkg:
  - MODE_TOGGLE = 1'b0, MODE_STROBE = 1'b1;
  - DEFAULT_TERM_50MHZ_1S constant.
- Sub-module blink_channel holds one channel's cnt/term/mode/ena state, the event compare and the OUT/TICK registers.
  - Its inputs are a decoded per-channel write strobe plus the shared WR_* data.
- Top level does WR_CH decode, range check and a generate loop of N_CH instances.

Test Plan:
- Reset then idle, DEFAULT_TERM overridden to 4 and N_CH = 4 → all OUT toggle together every 5 cycles (first toggle visible 5 cycles after reset release); TICK pulses 1 cycle every 5 cycles.
- Write ch1 term = 0, mode = strobe → OUT[1] and TICK[1] are high every cycle starting 1 cycle after the write edge; ch0, ch2 and ch3 cadence undisturbed.
- Write ch2 term = 2, toggle, at the cycle where ch2 cnt == term → no TICK[2] that cycle; next toggle exactly 3 cycles after the write edge.
- Write ch3 ena = 0 while OUT[3] = 1, toggle mode → OUT[3] stays 1 and TICK[3] stays 0 for 20 cycles. Re-enable with term = 1 → toggle 2 cycles after the write.
- WR_CH = 5 with N_CH = 4 → no output or period change on any channel over 3 full periods.
- Assert RST mid-period with OUT = 0b1010 → next cycle OUT = 0, TICK = 0, all terms back to DEFAULT_TERM; a WR_EN asserted in the same cycle as RST has no effect.

Source files
------------

// File: rtl/multi_blinker_pkg.sv
// Shared constants and helpers for the multi-channel blinker.
// Holds the mode encoding and the default 1 s terminal count.
package multi_blinker_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_STROBE = 1'b1;

  // One event per second at 50 MHz: period = term + 1 cycles.
  localparam logic [31:0] DEFAULT_TERM_50MHZ_1S = 32'd49_999_999;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/blink_channel.sv
// One blinker channel: up-counter with terminal-count wrap, config registers
// and registered OUT/TICK. A write on this channel overrides a same-cycle event.
module blink_channel
  import multi_blinker_pkg::*;
#(
  parameter int unsigned      CNT_W        = 32,
  parameter logic [CNT_W-1:0] DEFAULT_TERM = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_sel,
  input  logic [CNT_W-1:0] wr_term,
  input  logic             wr_mode,
  input  logic             wr_ena,
  output logic             out_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] term_q, term_d;
  logic             mode_q, mode_d;
  logic             ena_q, ena_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             evt;

  assign evt = ena_q && (cnt_q == term_q);

  always_comb begin
    cnt_d  = cnt_q;
    term_d = term_q;
    mode_d = mode_q;
    ena_d  = ena_q;
    out_d  = out_q;
    tick_d = 1'b0;
    if (wr_sel) begin
      term_d = wr_term;
      mode_d = wr_mode;
      ena_d  = wr_ena;
      cnt_d  = '0;
      out_d  = (wr_mode == MODE_STROBE) ? 1'b0 : out_q;
    end else if (evt) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      out_d  = (mode_q == MODE_STROBE) ? 1'b1 : ~out_q;
    end else begin
      // Counting and disabled both land here; strobe output is low between events.
      cnt_d = ena_q ? (cnt_q + CNT_W'(1)) : '0;
      if (mode_q == MODE_STROBE) out_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      term_q <= DEFAULT_TERM;
      mode_q <= MODE_TOGGLE;
      ena_q  <= 1'b1;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      term_q <= term_d;
      mode_q <= mode_d;
      ena_q  <= ena_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign out_o  = out_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/multi_blinker.sv
// Multi-channel programmable blinker: decodes the config write port and
// fans it out to N_CH independent blink_channel instances.
module multi_blinker
  import multi_blinker_pkg::*;
#(
  parameter int               N_CH         = 4,
  parameter int unsigned      CNT_W        = 32,
  parameter logic [CNT_W-1:0] DEFAULT_TERM = CNT_W'(DEFAULT_TERM_50MHZ_1S),
  localparam int              CH_W         = ch_width(N_CH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WR_EN,
  input  logic [CH_W-1:0]  WR_CH,
  input  logic [CNT_W-1:0] WR_TERM,
  input  logic             WR_MODE,
  input  logic             WR_ENA,
  output logic [N_CH-1:0]  OUT,
  output logic [N_CH-1:0]  TICK
);

  localparam logic [CH_W:0] N_CH_EXT = (CH_W + 1)'(N_CH);

  logic            wr_valid;
  logic [N_CH-1:0] wr_sel;

  // Out-of-range channel indices are dropped here so no instance sees them.
  assign wr_valid = WR_EN && ({1'b0, WR_CH} < N_CH_EXT);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr_sel[i] = wr_valid && (WR_CH == CH_W'(i));

    blink_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_TERM (DEFAULT_TERM)
    ) u_ch (
      .clk     (CLK),
      .rst     (RST),
      .wr_sel  (wr_sel[i]),
      .wr_term (WR_TERM),
      .wr_mode (WR_MODE),
      .wr_ena  (WR_ENA),
      .out_o   (OUT[i]),
      .tick_o  (TICK[i])
    );
  end

endmodule

// File: tb/tb_multi_blinker.sv
// Self-checking bench for multi_blinker; reference model schedules each
// channel's next event as an absolute cycle number.
module tb_multi_blinker;

  localparam int N_CH = 5;
  localparam int CNT_W = 8;
  localparam int CH_W = 3;
  localparam int DEF = 4;

  logic CLK = 1'b0;
  logic RST, WR_EN, WR_MODE, WR_ENA;
  logic [CH_W-1:0] WR_CH;
  logic [CNT_W-1:0] WR_TERM;
  logic [N_CH-1:0] OUT, TICK;

  int total = 0;
  int bad = 0;

  logic [N_CH-1:0] m_out, m_tick;
  int m_term[N_CH];
  bit m_mode[N_CH];
  bit m_ena[N_CH];
  longint m_nxt[N_CH];
  longint cyc = 0;

  multi_blinker #(
    .N_CH(N_CH), .CNT_W(CNT_W), .DEFAULT_TERM(CNT_W'(DEF))
  ) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_CH(WR_CH), .WR_TERM(WR_TERM),
    .WR_MODE(WR_MODE), .WR_ENA(WR_ENA), .OUT(OUT), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle of stimulus, advance the reference model over the edge.
  task automatic step(input bit rst, input bit wen, input int ch, input int term,
                      input bit mode, input bit ena);
    RST = rst; WR_EN = wen; WR_CH = CH_W'(ch); WR_TERM = CNT_W'(term);
    WR_MODE = mode; WR_ENA = ena;
    @(posedge CLK);
    cyc++;
    for (int c = 0; c < N_CH; c++) begin
      if (rst) begin
        m_term[c] = DEF; m_mode[c] = 0; m_ena[c] = 1;
        m_out[c] = 0; m_tick[c] = 0; m_nxt[c] = cyc + DEF + 1;
      end else if (wen && ch == c) begin
        m_term[c] = term; m_mode[c] = mode; m_ena[c] = ena;
        m_nxt[c] = cyc + term + 1; m_tick[c] = 0;
        if (mode) m_out[c] = 0;
      end else if (m_ena[c] && cyc == m_nxt[c]) begin
        m_tick[c] = 1;
        m_nxt[c] += m_term[c] + 1;
        m_out[c] = m_mode[c] ? 1'b1 : ~m_out[c];
      end else begin
        m_tick[c] = 0;
        if (m_mode[c]) m_out[c] = 0;
      end
    end
    #1;
    RST = 0; WR_EN = 0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    total++;
    if (OUT !== '0 || TICK !== '0) begin
      bad++;
      $display("FAIL reset: OUT=%b TICK=%b want 0/0", OUT, TICK);
    end
  endtask

  task automatic test_cadence();
    logic [N_CH-1:0] w_out, w_tick;
    for (int k = 1; k <= 15; k++) begin
      idle();
      w_tick = (k % 5 == 0) ? '1 : '0;
      w_out  = ((k / 5) % 2 == 1) ? '1 : '0;
      total++;
      if (OUT !== w_out || TICK !== w_tick || OUT !== m_out || TICK !== m_tick) begin
        bad++;
        $display("FAIL cadence k=%0d: OUT=%b TICK=%b want OUT=%b TICK=%b", k, OUT, TICK, w_out, w_tick);
      end
    end
  endtask

  task automatic test_strobe_term0();
    step(0, 1, 1, 0, 1, 1);
    for (int k = 0; k < 12; k++) begin
      idle();
      total++;
      if (OUT[1] !== 1'b1 || TICK[1] !== 1'b1 || OUT !== m_out || TICK !== m_tick) begin
        bad++;
        $display("FAIL strobe0 k=%0d: OUT=%b TICK=%b want OUT=%b TICK=%b", k, OUT, TICK, m_out, m_tick);
      end
    end
  endtask

  task automatic test_collision();
    bit found = 0;
    logic prev;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_nxt[2] == cyc + 1) found = 1;
      else idle();
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL collision_setup: event slot not reached, got 0 want 1");
    end
    prev = m_out[2];
    step(0, 1, 2, 2, 0, 1);
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) idle();
      total++;
      if (TICK[2] !== (k == 3) || OUT[2] !== ((k == 3) ? ~prev : prev) ||
          OUT !== m_out || TICK !== m_tick) begin
        bad++;
        $display("FAIL collision k=%0d: OUT=%b TICK=%b want OUT=%b TICK=%b", k, OUT, TICK, m_out, m_tick);
      end
    end
  endtask

  task automatic test_disable();
    for (int k = 0; k < 20 && m_out[3] !== 1'b1; k++) idle();
    total++;
    if (OUT[3] !== 1'b1) begin
      bad++;
      $display("FAIL disable_setup: OUT[3]=%b want 1", OUT[3]);
    end
    step(0, 1, 3, 7, 0, 0);
    for (int k = 0; k < 20; k++) begin
      idle();
      total++;
      if (OUT[3] !== 1'b1 || TICK[3] !== 1'b0 || OUT !== m_out || TICK !== m_tick) begin
        bad++;
        $display("FAIL disable k=%0d: OUT=%b TICK=%b want OUT=%b TICK=%b", k, OUT, TICK, m_out, m_tick);
      end
    end
    step(0, 1, 3, 1, 0, 1);
    for (int k = 0; k <= 2; k++) begin
      if (k > 0) idle();
      total++;
      if (OUT[3] !== (k != 2) || TICK[3] !== (k == 2) || OUT !== m_out || TICK !== m_tick) begin
        bad++;
        $display("FAIL reenable k=%0d: OUT=%b TICK=%b want OUT=%b TICK=%b", k, OUT, TICK, m_out, m_tick);
      end
    end
  endtask

  task automatic test_invalid_write();
    for (int w = 5; w <= 7; w++) begin
      step(0, 1, w, 0, 1, 0);
      for (int k = 0; k < 12; k++) begin
        if (k > 0) idle();
        total++;
        if (OUT !== m_out || TICK !== m_tick) begin
          bad++;
          $display("FAIL invalid ch=%0d k=%0d: OUT=%b TICK=%b want OUT=%b TICK=%b", w, k, OUT, TICK, m_out, m_tick);
        end
      end
    end
  endtask

  task automatic test_max_term();
    step(0, 1, 4, 255, 0, 1);
    for (int k = 1; k <= 258; k++) begin
      idle();
      total++;
      if (TICK[4] !== (k == 256) || OUT !== m_out || TICK !== m_tick) begin
        bad++;
        $display("FAIL maxterm k=%0d: OUT=%b TICK=%b want OUT=%b TICK=%b", k, OUT, TICK, m_out, m_tick);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) idle();
    step(0, 1, 0, 9, 0, 0);
    step(0, 1, 2, 9, 0, 0);
    step(0, 1, 4, 9, 0, 0);
    idle(); idle(); idle(); idle();
    total++;
    if (OUT !== 5'b10101 || OUT !== m_out) begin
      bad++;
      $display("FAIL reset_mid_setup: OUT=%b want %b", OUT, 5'b10101);
    end
    step(1, 1, 1, 0, 1, 1);
    total++;
    if (OUT !== '0 || TICK !== '0) begin
      bad++;
      $display("FAIL reset_mid: OUT=%b TICK=%b want 0/0", OUT, TICK);
    end
    for (int k = 1; k <= 5; k++) begin
      idle();
      total++;
      if (TICK !== ((k == 5) ? 5'b11111 : 5'b00000) || OUT !== m_out || TICK !== m_tick) begin
        bad++;
        $display("FAIL reset_mid_cadence k=%0d: OUT=%b TICK=%b want OUT=%b TICK=%b", k, OUT, TICK, m_out, m_tick);
      end
    end
  endtask

  task automatic test_random();
    int r, t;
    for (int k = 0; k < 800; k++) begin
      r = $urandom_range(0, 99);
      t = ($urandom_range(0, 19) == 0) ? 255 : $urandom_range(0, 9);
      if (r < 2) step(1, $urandom_range(0, 1), $urandom_range(0, 7), t, 1'($urandom_range(0, 1)), 1'b1);
      else if (r < 22) step(0, 1, $urandom_range(0, 7), t, 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 3) != 0));
      else idle();
      total++;
      if (OUT !== m_out || TICK !== m_tick) begin
        bad++;
        $display("FAIL random k=%0d: OUT=%b TICK=%b want OUT=%b TICK=%b", k, OUT, TICK, m_out, m_tick);
      end
    end
  endtask

  initial begin
    RST = 1; WR_EN = 0; WR_CH = '0; WR_TERM = '0; WR_MODE = 0; WR_ENA = 0;
    m_out = '0; m_tick = '0;
    test_reset();
    test_cadence();
    test_strobe_term0();
    test_collision();
    test_disable();
    test_invalid_write();
    test_max_term();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
